// File: rtl/bcd_score_counter_if.sv
// Control and status bundle between the game datapath and the BCD score counter.
// The master drives the count controls; the slave returns score, flags and best score.
interface bcd_score_counter_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic         CLR;
    logic         EN;
    logic         HOLD;
    logic         UP;
    logic [3:0]   STEP;
    logic         SAT;
    logic         LOAD;
    logic [W-1:0] LOAD_VAL;
    logic [W-1:0] Q;
    logic         CA;
    logic         AT_MAX;
    logic         AT_ZERO;
    logic [W-1:0] BEST;
    logic         NEW_BEST;

    modport master (
        output CLR, EN, HOLD, UP, STEP, SAT, LOAD, LOAD_VAL,
        input  Q, CA, AT_MAX, AT_ZERO, BEST, NEW_BEST
    );

    modport slave (
        input  CLR, EN, HOLD, UP, STEP, SAT, LOAD, LOAD_VAL,
        output Q, CA, AT_MAX, AT_ZERO, BEST, NEW_BEST
    );
endinterface

// File: rtl/bcd_score_counter.sv
// N-digit BCD up/down score counter with load, wrap/saturate and a best-score register.
// Q/CA update one edge after a request and BEST trails Q by one more edge; no backpressure (HOLD only pauses counting).
module bcd_score_counter #(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS
) (
    input  logic                CLK,
    input  logic                RESET_N,
    bcd_score_counter_if.slave  bus
);
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [W-1:0] r_q;
    logic         r_ca;
    logic [W-1:0] r_best;
    logic         r_new_best;

    logic [3:0]   w_step;
    logic [W-1:0] w_load;
    logic [W-1:0] w_up_q;
    logic [W-1:0] w_dn_q;
    logic         w_up_cy;
    logic         w_dn_bw;
    logic [3:0]   w_dig;
    logic [3:0]   w_add;
    logic [4:0]   w_t;
    logic [4:0]   w_s;

    assign w_step = (bus.STEP > 4'd9) ? 4'd9 : bus.STEP;

    // Per-digit decimal add and subtract; the step enters at the units digit only.
    always_comb begin
        w_load  = '0;
        w_up_q  = '0;
        w_dn_q  = '0;
        w_up_cy = 1'b0;
        w_dn_bw = 1'b0;
        w_dig   = '0;
        w_add   = '0;
        w_t     = '0;
        w_s     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load[4*i +: 4] = (bus.LOAD_VAL[4*i +: 4] > 4'd9) ? 4'd9 : bus.LOAD_VAL[4*i +: 4];
            w_dig = r_q[4*i +: 4];
            w_add = (i == 0) ? w_step : 4'd0;

            w_t = {1'b0, w_dig} + {1'b0, w_add} + {4'd0, w_up_cy};
            if (w_t >= 5'd10) begin
                w_up_q[4*i +: 4] = 4'(w_t - 5'd10);
                w_up_cy          = 1'b1;
            end else begin
                w_up_q[4*i +: 4] = w_t[3:0];
                w_up_cy          = 1'b0;
            end

            w_s = {1'b0, w_add} + {4'd0, w_dn_bw};
            if ({1'b0, w_dig} < w_s) begin
                w_dn_q[4*i +: 4] = 4'({1'b0, w_dig} + 5'd10 - w_s);
                w_dn_bw          = 1'b1;
            end else begin
                w_dn_q[4*i +: 4] = 4'({1'b0, w_dig} - w_s);
                w_dn_bw          = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_q  <= '0;
            r_ca <= 1'b0;
        end else if (bus.CLR) begin
            r_q  <= '0;
            r_ca <= 1'b0;
        end else if (bus.LOAD) begin
            r_q  <= w_load;
            r_ca <= 1'b0;
        end else if (bus.EN && !bus.HOLD) begin
            if (bus.UP) begin
                r_q  <= (w_up_cy && bus.SAT) ? ALL_NINES : w_up_q;
                r_ca <= w_up_cy;
            end else begin
                r_q  <= (w_dn_bw && bus.SAT) ? '0 : w_dn_q;
                r_ca <= w_dn_bw;
            end
        end else begin
            r_ca <= 1'b0;
        end
    end

    // Valid BCD orders the same as plain binary, so a vector compare is an MSD-first digit compare.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_best     <= '0;
            r_new_best <= 1'b0;
        end else if (r_q > r_best) begin
            r_best     <= r_q;
            r_new_best <= 1'b1;
        end else begin
            r_new_best <= 1'b0;
        end
    end

    assign bus.Q        = r_q;
    assign bus.CA       = r_ca;
    assign bus.BEST     = r_best;
    assign bus.NEW_BEST = r_new_best;
    assign bus.AT_MAX   = (r_q == ALL_NINES);
    assign bus.AT_ZERO  = (r_q == '0);
endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed and random checks of the BCD score counter against an integer-arithmetic model.
module tb_bcd_score_counter;
    localparam int DIGITS = 4;
    localparam int MODV   = 10000;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    int   m_q, m_best;
    bit   m_ca, m_nb;

    bcd_score_counter_if #(.DIGITS(DIGITS)) bus();

    bcd_score_counter #(.DIGITS(DIGITS)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Clamp each digit to 9 first, then read the value as a decimal number.
    function automatic int bcd2int(input logic [15:0] b);
        int r, d;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Q"},        32'(bus.Q),        32'(int2bcd(m_q)));
        check({tag, ".CA"},       32'(bus.CA),       32'(m_ca));
        check({tag, ".BEST"},     32'(bus.BEST),     32'(int2bcd(m_best)));
        check({tag, ".NEW_BEST"}, 32'(bus.NEW_BEST), 32'(m_nb));
        check({tag, ".AT_MAX"},   32'(bus.AT_MAX),   32'(m_q == MODV - 1));
        check({tag, ".AT_ZERO"},  32'(bus.AT_ZERO),  32'(m_q == 0));
    endtask

    task automatic cyc(input string tag, input bit clr, input bit load, input bit en, input bit hold,
                       input bit up, input int step, input bit sat, input logic [15:0] lv);
        int s, nq, t;
        bit nca;
        bus.CLR = clr; bus.LOAD = load; bus.EN = en; bus.HOLD = hold;
        bus.UP = up; bus.STEP = 4'(step); bus.SAT = sat; bus.LOAD_VAL = lv;
        s   = (step > 9) ? 9 : step;
        nq  = m_q;
        nca = 1'b0;
        if (clr) begin
            nq = 0;
        end else if (load) begin
            nq = bcd2int(lv);
        end else if (en && !hold) begin
            if (up) begin
                t = m_q + s;
                if (t >= MODV) begin
                    nca = 1'b1;
                    nq  = sat ? MODV - 1 : t - MODV;
                end else nq = t;
            end else begin
                if (s > m_q) begin
                    nca = 1'b1;
                    nq  = sat ? 0 : MODV + m_q - s;
                end else nq = m_q - s;
            end
        end
        @(posedge CLK);
        #1;
        m_nb = (m_q > m_best);
        if (m_nb) m_best = m_q;
        m_q  = nq;
        m_ca = nca;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 1, 0, 0, 16'h0);
    endtask

    task automatic load(input string tag, input logic [15:0] v);
        cyc(tag, 0, 1, 0, 0, 1, 0, 0, v);
    endtask

    task automatic mid_reset(input string tag);
        bus.CLR = 0; bus.LOAD = 0; bus.EN = 0; bus.HOLD = 0;
        #2;
        RESET_N = 1'b0;
        #1;
        m_q = 0; m_best = 0; m_ca = 0; m_nb = 0;
        check_all(tag);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        bus.CLR = 0; bus.LOAD = 0; bus.EN = 0; bus.HOLD = 0;
        bus.UP = 1; bus.STEP = 0; bus.SAT = 0; bus.LOAD_VAL = '0;
        m_q = 0; m_best = 0; m_ca = 0; m_nb = 0;
        #12;
        check_all("reset");
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Reset mid-count, then stay idle
        load("ld123", 16'h0123);
        cyc("cnt", 0, 0, 1, 0, 1, 1, 0, 16'h0);
        mid_reset("rst_mid");
        for (int i = 0; i < 5; i++) idle("idle0");

        // Up ripple, wrap, saturate
        load("ld0998", 16'h0998);
        cyc("up_ripple", 0, 0, 1, 0, 1, 3, 0, 16'h0);
        load("ld9998", 16'h9998);
        cyc("up_wrap", 0, 0, 1, 0, 1, 5, 0, 16'h0);
        idle("ca_drop");
        load("ld9998s", 16'h9998);
        cyc("up_sat", 0, 0, 1, 0, 1, 5, 1, 16'h0);
        cyc("up_sat_hold9", 0, 0, 1, 0, 1, 1, 1, 16'h0);
        cyc("step0", 0, 0, 1, 0, 1, 0, 1, 16'h0);

        // Down borrow, wrap, saturate
        load("ld1000", 16'h1000);
        cyc("dn_borrow", 0, 0, 1, 0, 0, 1, 0, 16'h0);
        load("ld0002", 16'h0002);
        cyc("dn_wrap", 0, 0, 1, 0, 0, 7, 0, 16'h0);
        load("ld0002s", 16'h0002);
        cyc("dn_sat", 0, 0, 1, 0, 0, 7, 1, 16'h0);
        cyc("dn_sat_at0", 0, 0, 1, 0, 0, 3, 1, 16'h0);

        // Priority
        load("ld0042", 16'h0042);
        cyc("clr_pri", 1, 1, 1, 0, 1, 5, 0, 16'h0777);
        cyc("load_pri", 0, 1, 1, 0, 1, 5, 0, 16'h0500);
        for (int i = 0; i < 3; i++) cyc("hold", 0, 0, 1, 1, 1, 4, 0, 16'h0);

        // Best score across two games
        mid_reset("rst_best");
        for (int i = 0; i < 5; i++) cyc("game1", 0, 0, 1, 0, 1, 1, 0, 16'h0);
        cyc("clr_game", 1, 0, 0, 0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) cyc("game2", 0, 0, 1, 0, 1, 1, 0, 16'h0);
        idle("game2_end");
        check("best_kept", 32'(bus.BEST), 32'h0005);

        // Sanitising
        load("ld00FA", 16'h00FA);
        cyc("clr0", 1, 0, 0, 0, 1, 0, 0, 16'h0);
        cyc("step_c", 0, 0, 1, 0, 1, 12, 0, 16'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom),
                int'($urandom_range(0, 15)), 1'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
